uart_rx_fifo: RTL and testbench

Standalone UART receiver with 16x oversampling, majority-vote bit sampling, false-start rejection, configurable framing and a small receive FIFO. It is the receive-side counterpart to the existing UART transmitter. It consumes the same shared 16x baud tick strobe and the same frame configuration fields. Received words, with per-word error flags, are presented on a valid/ready interface so a host can drain them without losing frames.

---
 rtl/uart_rx_fifo.sv | 160 ++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// UART receiver with 16x oversampling, 3-sample majority vote and configurable framing,
// feeding a small FIFO that the host drains over a valid/ready interface.
module uart_rx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tick16,
  input  logic                     rx,
  input  logic [1:0]               data_len,
  input  logic                     parity_en,
  input  logic                     parity_even,
  input  logic                     stop_sel,
  output logic [7:0]               out_data,
  output logic                     out_perr,
  output logic                     out_ferr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     overrun,
  input  logic                     clr_ovr,
  output logic                     brk,
  output logic                     rx_busy,
  output logic [$clog2(DEPTH):0]   fifo_level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;

  state_t      state;
  logic        rx_meta, rx_s;
  logic [3:0]  ocnt;
  logic [2:0]  bit_idx;
  logic        s7, s8;
  logic [7:0]  data;
  logic        perr, ferr, par_bit;
  logic [1:0]  len_q;
  logic        pen_q, peven_q, stop_q;

  logic        majority, ferr_next, done;
  logic [9:0]  mem [DEPTH];
  logic [AW:0] wptr, rptr;
  logic        full, pop;

  assign majority  = (s7 & s8) | (s7 & rx_s) | (s8 & rx_s);
  assign ferr_next = ferr | ~majority;
  assign done      = tick16 && (ocnt == 4'd9) &&
                     ((state == STOP1 && !stop_q) || state == STOP2);
  assign rx_busy   = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Samples at ocnt 7 and 8 are held so the vote can complete with the live sample at ocnt 9.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ocnt    <= '0;
      bit_idx <= '0;
      s7      <= 1'b1;
      s8      <= 1'b1;
      data    <= '0;
      perr    <= 1'b0;
      ferr    <= 1'b0;
      par_bit <= 1'b0;
      len_q   <= '0;
      pen_q   <= 1'b0;
      peven_q <= 1'b0;
      stop_q  <= 1'b0;
    end else if (tick16) begin
      ocnt <= ocnt + 4'd1;
      if (ocnt == 4'd7) s7 <= rx_s;
      if (ocnt == 4'd8) s8 <= rx_s;
      case (state)
        IDLE: begin
          ocnt <= '0;
          if (!rx_s) begin
            state   <= START;
            bit_idx <= '0;
            data    <= '0;
            perr    <= 1'b0;
            ferr    <= 1'b0;
            par_bit <= 1'b0;
            len_q   <= data_len;
            pen_q   <= parity_en;
            peven_q <= parity_even;
            stop_q  <= stop_sel;
          end
        end
        START: begin
          if (ocnt == 4'd9 && majority) state <= IDLE;
          else if (ocnt == 4'd15)       state <= DATA;
        end
        DATA: begin
          if (ocnt == 4'd9) data[bit_idx] <= majority;
          if (ocnt == 4'd15) begin
            if (bit_idx == 3'd4 + {1'b0, len_q}) state <= pen_q ? PARITY : STOP1;
            else bit_idx <= bit_idx + 3'd1;
          end
        end
        PARITY: begin
          if (ocnt == 4'd9) begin
            par_bit <= majority;
            perr    <= (majority != (peven_q ? ^data : ~^data));
          end
          if (ocnt == 4'd15) state <= STOP1;
        end
        // A single-stop frame ends mid-bit so an early next start bit can still be caught.
        STOP1: begin
          if (ocnt == 4'd9) begin
            ferr <= ferr_next;
            if (!stop_q) state <= IDLE;
          end else if (ocnt == 4'd15) begin
            state <= STOP2;
          end
        end
        STOP2: begin
          if (ocnt == 4'd9) begin
            ferr  <= ferr_next;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign fifo_level = wptr - rptr;
  assign out_valid  = (wptr != rptr);
  assign full       = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop        = out_valid && out_ready;
  assign {out_ferr, out_perr, out_data} = mem[rptr[AW-1:0]];

  // When full, a pop in the same cycle frees the slot the incoming frame overwrites.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr    <= '0;
      rptr    <= '0;
      overrun <= 1'b0;
      brk     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      brk <= done && (data == 8'd0) && ferr_next && !par_bit;
      if (pop) rptr <= rptr + PTR_ONE;
      if (done && (!full || pop)) begin
        mem[wptr[AW-1:0]] <= {ferr_next, perr, data};
        wptr <= wptr + PTR_ONE;
      end
      if (done && full && !pop) overrun <= 1'b1;
      else if (clr_ovr)         overrun <= 1'b0;
    end
  end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: frames are serialised from a parity/framing model,
// expected words queued at issue time and compared by a monitor whenever the host pops.
module tb_uart_rx_fifo;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic       ferr;
    logic       perr;
    logic [7:0] data;
  } word_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick16 = 1'b0;
  logic       rx;
  logic [1:0] data_len;
  logic       parity_en, parity_even, stop_sel;
  logic [7:0] out_data;
  logic       out_perr, out_ferr, out_valid, out_ready;
  logic       overrun, clr_ovr, brk, rx_busy;
  logic [2:0] fifo_level;

  int    checks = 0;
  int    errors = 0;
  int    brk_seen = 0;
  int    brk_exp = 0;
  int    tick_div = 0;
  logic  exp_ovr;
  word_t exp_q[$];

  uart_rx_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .tick16(tick16), .rx(rx),
    .data_len(data_len), .parity_en(parity_en), .parity_even(parity_even),
    .stop_sel(stop_sel), .out_data(out_data), .out_perr(out_perr),
    .out_ferr(out_ferr), .out_valid(out_valid), .out_ready(out_ready),
    .overrun(overrun), .clr_ovr(clr_ovr), .brk(brk), .rx_busy(rx_busy),
    .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    tick_div <= (tick_div == 3) ? 0 : tick_div + 1;
    tick16   <= (tick_div == 3);
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted head word is matched against the oldest expected word.
  always @(negedge clk) begin
    word_t e;
    if (!rst) begin
      if (brk) brk_seen++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_word: got 0x%0h, expected none", {out_ferr, out_perr, out_data});
        end else begin
          e = exp_q.pop_front();
          checkOutput("rx_word", {22'd0, out_ferr, out_perr, out_data}, {22'd0, e});
        end
      end
    end
  end

  task automatic bit_time(input logic v);
    rx = v;
    repeat (64) @(posedge clk);
    #1;
  endtask

  // Builds the expected word from the framing rules, then serialises the frame LSB first.
  task automatic applyStimulus(input logic [7:0] d, input logic [1:0] dl, input logic pe,
                               input logic pev, input logic ss, input logic flip,
                               input logic s1, input logic s2, input int gap);
    int    n;
    int    ones;
    logic  [7:0] md;
    logic  pbit;
    word_t w;
    n    = 5 + int'(dl);
    md   = d & 8'((1 << n) - 1);
    ones = $countones(md);
    pbit = (pev ? ((ones % 2) == 1) : ((ones % 2) == 0)) ^ flip;
    w.data = md;
    w.perr = pe && flip;
    w.ferr = !s1 || (ss && !s2);
    if (md == 8'd0 && w.ferr && (!pe || !pbit)) brk_exp++;
    if (exp_q.size() >= DEPTH) exp_ovr = 1'b1;
    else exp_q.push_back(w);
    data_len    = dl;
    parity_en   = pe;
    parity_even = pev;
    stop_sel    = ss;
    bit_time(1'b0);
    for (int i = 0; i < n; i++) bit_time(md[i]);
    if (pe) bit_time(pbit);
    bit_time(s1);
    if (ss) bit_time(s2);
    for (int i = 0; i < gap; i++) bit_time(1'b1);
  endtask

  task automatic wait_drain();
    int i;
    i = 0;
    while (fifo_level != 0 && i < 200) begin
      @(posedge clk);
      #1;
      i++;
    end
    checkOutput("drain_level", 32'(fifo_level), 0);
  endtask

  initial begin
    int brk_before;
    rst = 1'b1; rx = 1'b1; out_ready = 1'b0; clr_ovr = 1'b0;
    data_len = 2'd3; parity_en = 1'b0; parity_even = 1'b0; stop_sel = 1'b0;
    exp_ovr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_valid", 32'(out_valid), 0);
    checkOutput("rst_level", 32'(fifo_level), 0);
    checkOutput("rst_overrun", 32'(overrun), 0);
    checkOutput("rst_brk", 32'(brk), 0);
    checkOutput("rst_busy", 32'(rx_busy), 0);
    checkOutput("rst_head", {22'd0, out_ferr, out_perr, out_data}, 0);
    rst = 1'b0;
    repeat (32) @(posedge clk);
    #1;

    $display("[TB] 8N1 frame 0xA5");
    applyStimulus(8'hA5, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1);
    checkOutput("a5_level", 32'(fifo_level), 1);
    checkOutput("a5_valid", 32'(out_valid), 1);
    checkOutput("a5_data", 32'(out_data), 32'hA5);
    checkOutput("a5_flags", {30'd0, out_ferr, out_perr}, 0);
    out_ready = 1'b1;
    wait_drain();
    checkOutput("a5_valid_after", 32'(out_valid), 0);

    $display("[TB] false start");
    rx = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    checkOutput("fs_busy", 32'(rx_busy), 1);
    repeat (12) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (64) @(posedge clk);
    #1;
    checkOutput("fs_busy_after", 32'(rx_busy), 0);
    checkOutput("fs_level", 32'(fifo_level), 0);

    $display("[TB] 7E1 parity");
    out_ready = 1'b0;
    applyStimulus(8'h41, 2'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1);
    checkOutput("7e1_bad_perr", 32'(out_perr), 1);
    checkOutput("7e1_bad_data", 32'(out_data), 32'h41);
    out_ready = 1'b1;
    wait_drain();
    out_ready = 1'b0;
    applyStimulus(8'h41, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1);
    checkOutput("7e1_good_perr", 32'(out_perr), 0);
    out_ready = 1'b1;
    wait_drain();

    $display("[TB] 8N2 framing and break");
    out_ready = 1'b0;
    applyStimulus(8'h3C, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1);
    checkOutput("8n2_ferr", 32'(out_ferr), 1);
    checkOutput("8n2_level", 32'(fifo_level), 1);
    out_ready = 1'b1;
    wait_drain();
    out_ready = 1'b0;
    brk_before = brk_seen;
    applyStimulus(8'h00, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1);
    checkOutput("brk_ferr", 32'(out_ferr), 1);
    checkOutput("brk_data", 32'(out_data), 0);
    checkOutput("brk_pulses", 32'(brk_seen - brk_before), 1);
    checkOutput("brk_level", 32'(fifo_level), 1);
    out_ready = 1'b1;
    wait_drain();

    $display("[TB] overrun");
    out_ready = 1'b0;
    for (int v = 1; v <= 5; v++)
      applyStimulus(8'(v), 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1);
    checkOutput("ovr_level", 32'(fifo_level), 4);
    checkOutput("ovr_set", 32'(overrun), 32'(exp_ovr));
    checkOutput("ovr_head", 32'(out_data), 1);
    out_ready = 1'b1;
    wait_drain();
    checkOutput("ovr_sticky", 32'(overrun), 1);
    clr_ovr = 1'b1;
    @(posedge clk);
    #1;
    clr_ovr = 1'b0;
    exp_ovr = 1'b0;
    checkOutput("ovr_clr", 32'(overrun), 0);

    $display("[TB] reset mid-frame");
    out_ready = 1'b0;
    for (int v = 0; v < 5; v++)
      applyStimulus(8'($urandom_range(0, 255)), 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1);
    checkOutput("pre_rst_overrun", 32'(overrun), 1);
    bit_time(1'b0);
    bit_time(1'b1);
    bit_time(1'b0);
    bit_time(1'b1);
    rx = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    checkOutput("mid_busy", 32'(rx_busy), 1);
    rst = 1'b1;
    #1;
    exp_q.delete();
    exp_ovr = 1'b0;
    checkOutput("mid_rst_busy", 32'(rx_busy), 0);
    checkOutput("mid_rst_valid", 32'(out_valid), 0);
    checkOutput("mid_rst_level", 32'(fifo_level), 0);
    checkOutput("mid_rst_overrun", 32'(overrun), 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (128) @(posedge clk);
    #1;
    checkOutput("post_rst_level", 32'(fifo_level), 0);
    out_ready = 1'b0;
    applyStimulus(8'h5A, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1);
    checkOutput("post_rst_data", 32'(out_data), 32'h5A);
    out_ready = 1'b1;
    wait_drain();

    $display("[TB] randomized frames");
    for (int k = 0; k < 25; k++) begin
      applyStimulus(8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                    int'($urandom_range(1, 2)));
    end
    wait_drain();
    checkOutput("scoreboard_empty", 32'(exp_q.size()), 0);
    checkOutput("brk_total", 32'(brk_seen), 32'(brk_exp));
    checkOutput("final_overrun", 32'(overrun), 32'(exp_ovr));
    checkOutput("final_busy", 32'(rx_busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
